// File: rtl/ama_riscv_csr_bank.sv
// Machine-mode CSR bank: tohost, mscratch, custom scratch registers and the
// mcycle/minstret counters with their read-only user-mode mirrors.
module ama_riscv_csr_bank #(
    parameter int CNT_W     = 64,
    parameter int N_SCRATCH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_en,
    input  logic        csr_we,
    input  logic        csr_ui,
    input  logic [1:0]  csr_op_sel,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_rs1,
    input  logic [4:0]  csr_uimm,
    input  logic        retire,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic [31:0] tohost,
    output logic        tohost_valid
);

    localparam int N_SCR_A = (N_SCRATCH > 0) ? N_SCRATCH : 1;

    logic [31:0]      tohost_q, mscratch_q, rdata_q;
    logic [31:0]      scratch_q [N_SCR_A];
    logic [CNT_W-1:0] mcycle_q, minstret_q, mcycle_d, minstret_d;
    logic             illegal_q, tohost_valid_q;

    logic [63:0]        cyc_ext_s, ins_ext_s, cyc_wr_s, ins_wr_s;
    logic [31:0]        src_s, old_s, new_s;
    logic               mapped_s, ro_s, wr_req_s, wr_s;
    logic               hit_tohost_s, hit_mscratch_s;
    logic               hit_cyc_lo_s, hit_cyc_hi_s, hit_ins_lo_s, hit_ins_hi_s;
    logic [N_SCR_A-1:0] scr_sel_s;

    assign cyc_ext_s = 64'(mcycle_q);
    assign ins_ext_s = 64'(minstret_q);

    // Address decode and old-value mux; unmapped addresses read as zero.
    always_comb begin
        mapped_s       = 1'b1;
        ro_s           = 1'b0;
        old_s          = 32'h0000_0000;
        hit_tohost_s   = 1'b0;
        hit_mscratch_s = 1'b0;
        hit_cyc_lo_s   = 1'b0;
        hit_cyc_hi_s   = 1'b0;
        hit_ins_lo_s   = 1'b0;
        hit_ins_hi_s   = 1'b0;
        scr_sel_s      = '0;
        case (csr_addr)
            12'h51E: begin hit_tohost_s   = 1'b1; old_s = tohost_q;   end
            12'h340: begin hit_mscratch_s = 1'b1; old_s = mscratch_q; end
            12'hB00: begin hit_cyc_lo_s   = 1'b1; old_s = cyc_ext_s[31:0];  end
            12'hB80: begin hit_cyc_hi_s   = 1'b1; old_s = cyc_ext_s[63:32]; end
            12'hB02: begin hit_ins_lo_s   = 1'b1; old_s = ins_ext_s[31:0];  end
            12'hB82: begin hit_ins_hi_s   = 1'b1; old_s = ins_ext_s[63:32]; end
            12'hC00: begin ro_s = 1'b1; old_s = cyc_ext_s[31:0];  end
            12'hC80: begin ro_s = 1'b1; old_s = cyc_ext_s[63:32]; end
            12'hC02: begin ro_s = 1'b1; old_s = ins_ext_s[31:0];  end
            12'hC82: begin ro_s = 1'b1; old_s = ins_ext_s[63:32]; end
            default: begin
                mapped_s = 1'b0;
                for (int i = 0; i < N_SCRATCH; i++) begin
                    if (csr_addr == 12'h7C0 + 12'(i)) begin
                        mapped_s     = 1'b1;
                        scr_sel_s[i] = 1'b1;
                        old_s        = scratch_q[i];
                    end else begin
                        scr_sel_s[i] = 1'b0;
                    end
                end
            end
        endcase
    end

    assign src_s    = csr_ui ? {27'b0, csr_uimm} : csr_rs1;
    assign wr_req_s = csr_en & csr_we & (csr_op_sel != 2'b00);
    assign wr_s     = wr_req_s & mapped_s & ~ro_s;

    // Read-modify-write operation on the addressed register.
    always_comb begin
        case (csr_op_sel)
            2'b01:   new_s = src_s;
            2'b10:   new_s = old_s | src_s;
            2'b11:   new_s = old_s & ~src_s;
            default: new_s = old_s;
        endcase
    end

    assign cyc_wr_s = hit_cyc_hi_s ? {new_s, cyc_ext_s[31:0]} : {cyc_ext_s[63:32], new_s};
    assign ins_wr_s = hit_ins_hi_s ? {new_s, ins_ext_s[31:0]} : {ins_ext_s[63:32], new_s};

    // A software write to either half replaces the counter and suppresses that cycle's increment.
    always_comb begin
        if (wr_s & (hit_cyc_lo_s | hit_cyc_hi_s)) begin
            mcycle_d = cyc_wr_s[CNT_W-1:0];
        end else begin
            mcycle_d = mcycle_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (wr_s & (hit_ins_lo_s | hit_ins_hi_s)) begin
            minstret_d = ins_wr_s[CNT_W-1:0];
        end else if (retire) begin
            minstret_d = minstret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            minstret_d = minstret_q;
        end
    end

    // State and registered outputs; reset overrides any same-cycle access.
    always_ff @(posedge clk) begin
        if (rst) begin
            tohost_q       <= 32'h0000_0000;
            mscratch_q     <= 32'h0000_0000;
            mcycle_q       <= '0;
            minstret_q     <= '0;
            rdata_q        <= 32'h0000_0000;
            illegal_q      <= 1'b0;
            tohost_valid_q <= 1'b0;
            for (int i = 0; i < N_SCRATCH; i++) begin
                scratch_q[i] <= 32'h0000_0000;
            end
        end else begin
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
            illegal_q      <= csr_en & (~mapped_s | (ro_s & wr_req_s));
            tohost_valid_q <= wr_s & hit_tohost_s;
            if (csr_en) begin
                rdata_q <= old_s;
            end
            if (wr_s & hit_tohost_s) begin
                tohost_q <= new_s;
            end
            if (wr_s & hit_mscratch_s) begin
                mscratch_q <= new_s;
            end
            for (int i = 0; i < N_SCRATCH; i++) begin
                if (wr_s & scr_sel_s[i]) begin
                    scratch_q[i] <= new_s;
                end
            end
        end
    end

    assign csr_rdata    = rdata_q;
    assign csr_illegal  = illegal_q;
    assign tohost       = tohost_q;
    assign tohost_valid = tohost_valid_q;

endmodule
